// File: rtl/alu_pipe.sv
// Handshaked execute ALU: single-cycle logic/arith/shift ops plus an iterative
// shift-add unsigned multiplier, with a registered result, flags and tag.
module alu_pipe #(
  parameter int WIDTH      = 16,
  parameter int TAG_W      = 4,
  parameter int ENABLE_MUL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] immediate,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             illegal,
  output logic             state_dbg
);

  // Handshake: a transfer happens on a clk edge where valid && ready are both
  // high; the producer holds its payload stable until that edge.

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t             state;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic [TAG_W-1:0]   mul_tag;

  logic [WIDTH-1:0]   src;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [SHW-1:0]     shamt;
  logic [WIDTH-1:0]   nres;
  logic               nc, nv, nill, nz, nn;
  logic               is_mul, accept;

  assign in_ready  = (state == S_IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (opcode == 4'b1000) && (ENABLE_MUL != 0);
  assign state_dbg = (state == S_MUL);
  assign acc_next  = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    src   = opcode[3] ? immediate : b;
    sum   = {1'b0, a} + {1'b0, src};
    // Subtract as a + ~src + 1 so carry means "no borrow".
    diff  = {1'b0, a} + {1'b0, ~src} + {{WIDTH{1'b0}}, 1'b1};
    shamt = b[SHW-1:0];
    nres  = '0;
    nc    = 1'b0;
    nv    = 1'b0;
    nill  = 1'b0;
    case (opcode)
      4'b0000: nres = a & b;
      4'b0001: nres = a | b;
      4'b0100: nres = a ^ b;
      4'b0010, 4'b1010: begin
        nres = sum[WIDTH-1:0];
        nc   = sum[WIDTH];
        nv   = (a[WIDTH-1] == src[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0011, 4'b1011: begin
        nres = diff[WIDTH-1:0];
        nc   = diff[WIDTH];
        nv   = (a[WIDTH-1] != src[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0101: nres = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'b0110: nres = a << shamt;
      4'b0111: nres = $unsigned($signed(a) >>> shamt);
      4'b1000: nill = (ENABLE_MUL == 0);
      default: nill = 1'b1;
    endcase
    nz = !nill && (nres == '0);
    nn = !nill && nres[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      out_valid  <= 1'b0;
      alu_result <= '0;
      out_tag    <= '0;
      zero       <= 1'b0;
      negative   <= 1'b0;
      carry      <= 1'b0;
      overflow   <= 1'b0;
      illegal    <= 1'b0;
      cnt        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      mul_tag    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (out_valid && out_ready) out_valid <= 1'b0;
          if (accept) begin
            if (is_mul) begin
              mcand   <= {{WIDTH{1'b0}}, a};
              mplier  <= b;
              acc     <= '0;
              cnt     <= '0;
              mul_tag <= in_tag;
              state   <= S_MUL;
            end else begin
              alu_result <= nres;
              out_tag    <= in_tag;
              zero       <= nz;
              negative   <= nn;
              carry      <= nc;
              overflow   <= nv;
              illegal    <= nill;
              out_valid  <= 1'b1;
            end
          end
        end
        S_MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + {{(CW-1){1'b0}}, 1'b1};
          // Last iteration: the product is complete in acc_next.
          if (cnt == CW'(WIDTH-1)) begin
            alu_result <= acc_next[WIDTH-1:0];
            overflow   <= |acc_next[2*WIDTH-1:WIDTH];
            carry      <= 1'b0;
            zero       <= ~|acc_next[WIDTH-1:0];
            negative   <= acc_next[WIDTH-1];
            illegal    <= 1'b0;
            out_tag    <= mul_tag;
            out_valid  <= 1'b1;
            cnt        <= '0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed handshake/flag scenarios followed by random
// traffic scored against an arithmetic reference model.
module tb_alu_pipe;
  localparam int W  = 16;
  localparam int TW = 4;

  typedef struct packed {
    logic [W-1:0]  res;
    logic [TW-1:0] tag;
    logic z, n, c, v, ill;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, out_valid, out_ready;
  logic [3:0]    opcode;
  logic [W-1:0]  a, b, immediate, alu_result;
  logic [TW-1:0] in_tag, out_tag;
  logic          zero, negative, carry, overflow, illegal, state_dbg;

  logic          in_valid_n, in_ready_n, out_valid_n;
  logic [3:0]    opcode_n;
  logic [W-1:0]  a_n, b_n, imm_n, res_n;
  logic [TW-1:0] tag_n, out_tag_n;
  logic          zero_n, neg_n, carry_n, ovf_n, ill_n, dbg_n;

  alu_pipe #(.WIDTH(W), .TAG_W(TW), .ENABLE_MUL(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .a(a), .b(b), .immediate(immediate), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result),
    .out_tag(out_tag), .zero(zero), .negative(negative), .carry(carry),
    .overflow(overflow), .illegal(illegal), .state_dbg(state_dbg)
  );

  alu_pipe #(.WIDTH(W), .TAG_W(TW), .ENABLE_MUL(0)) dut_nomul (
    .clk(clk), .rst(rst), .in_valid(in_valid_n), .in_ready(in_ready_n),
    .opcode(opcode_n), .a(a_n), .b(b_n), .immediate(imm_n), .in_tag(tag_n),
    .out_valid(out_valid_n), .out_ready(1'b1), .alu_result(res_n),
    .out_tag(out_tag_n), .zero(zero_n), .negative(neg_n), .carry(carry_n),
    .overflow(ovf_n), .illegal(ill_n), .state_dbg(dbg_n)
  );

  // ---------------- reference model ----------------
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] x, y, imm,
                                 input logic [TW-1:0] tg, input bit mul_en);
    exp_t   e;
    longint ux, uy, sx, sy, su, ss, r, lim, smax, smin;
    int     amt;
    e    = '0;
    e.tag = tg;
    lim  = longint'(1) << W;
    smax = lim / 2 - 1;
    smin = -(lim / 2);
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    su = (op == 4'd10 || op == 4'd11) ? longint'(imm) : uy;
    ss = (op == 4'd10 || op == 4'd11) ? longint'($signed(imm)) : sy;
    amt = int'(uy % W);
    r = 0;
    case (op)
      4'd0: r = ux & uy;
      4'd1: r = ux | uy;
      4'd4: r = ux ^ uy;
      4'd2, 4'd10: begin
        r   = ux + su;
        e.c = (r >= lim);
        e.v = (sx + ss > smax) || (sx + ss < smin);
      end
      4'd3, 4'd11: begin
        r   = ux - su;
        e.c = (ux >= su);
        e.v = (sx - ss > smax) || (sx - ss < smin);
      end
      4'd5: r = (sx < sy) ? 1 : 0;
      4'd6: r = ux << amt;
      4'd7: r = sx >>> amt;
      4'd8: begin
        if (mul_en) begin
          r   = ux * uy;
          e.v = ((r >> W) != 0);
        end else e.ill = 1'b1;
      end
      default: e.ill = 1'b1;
    endcase
    if (!e.ill) begin
      e.res = W'(r);
      e.z   = (e.res == '0);
      e.n   = e.res[W-1];
    end
    return e;
  endfunction

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [EXP_W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic chk_out(input string name, input exp_t e);
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_res"},   32'(alu_result), 32'(e.res));
    chk({name, "_tag"},   32'(out_tag), 32'(e.tag));
    chk({name, "_zero"},  32'(zero), 32'(e.z));
    chk({name, "_neg"},   32'(negative), 32'(e.n));
    chk({name, "_carry"}, 32'(carry), 32'(e.c));
    chk({name, "_ovf"},   32'(overflow), 32'(e.v));
    chk({name, "_ill"},   32'(illegal), 32'(e.ill));
  endtask

  // ---------------- driver ----------------
  // Entered at a negedge; leaves at the negedge after the accepting edge.
  task automatic send(input logic [3:0] op, input logic [W-1:0] x, y, imm,
                      input logic [TW-1:0] tg);
    opcode = op; a = x; b = y; immediate = imm; in_tag = tg; in_valid = 1'b1;
    #1;
    for (int i = 0; i < 40 && !in_ready; i++) begin
      @(negedge clk);
      #1;
    end
    chk("accept_wait", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   bad;
    bit   acc_now;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    opcode = '0; a = '0; b = '0; immediate = '0; in_tag = '0;
    in_valid_n = 1'b0; opcode_n = '0; a_n = '0; b_n = '0; imm_n = '0; tag_n = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_res",   32'(alu_result), 32'd0);
    chk("rst_tag",   32'(out_tag), 32'd0);
    chk("rst_flags", 32'({zero, negative, carry, overflow, illegal}), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'd0);
    rst = 1'b0;
    #1 chk("rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Reset in the middle of a multiply
    @(negedge clk);
    send(4'd8, 16'd3, 16'd5, 16'd0, 4'd2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midmul_valid", 32'(out_valid), 32'd0);
    chk("midmul_res",   32'(alu_result), 32'd0);
    #1 chk("midmul_ready", 32'(in_ready), 32'd1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    chk("midmul_stray", 32'(bad), 32'd0);

    // Back-to-back ADD / SUB
    send(4'd2, 16'h0005, 16'h0003, 16'h0, 4'd1);
    chk_out("add1", model(4'd2, 16'h0005, 16'h0003, 16'h0, 4'd1, 1));
    chk("add1_lit", 32'(alu_result), 32'h0008);
    #1 chk("b2b_ready", 32'(in_ready), 32'd1);
    send(4'd3, 16'h0003, 16'h0003, 16'h0, 4'd2);
    chk_out("sub1", model(4'd3, 16'h0003, 16'h0003, 16'h0, 4'd2, 1));
    chk("sub1_lit", 32'({alu_result, zero, carry}), {16'h0, 16'h0003});

    // Overflow and carry corners
    send(4'd10, 16'h7FFF, 16'h0000, 16'h0001, 4'd3);
    chk("addi_lit", 32'({alu_result, overflow, negative, carry}), {16'h0, 16'h8000, 3'b110});
    chk_out("addi", model(4'd10, 16'h7FFF, 16'h0000, 16'h0001, 4'd3, 1));
    send(4'd2, 16'hFFFF, 16'h0001, 16'h0, 4'd4);
    chk("addc_lit", 32'({alu_result, carry, zero, overflow}), {16'h0, 16'h0000, 3'b110});

    // Multiply latency and result
    send(4'd8, 16'h0100, 16'h0101, 16'h0, 4'd5);
    chk("mul_busy_ready", 32'(in_ready), 32'd0);
    bad = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i < 16 && (out_valid || in_ready)) bad++;
    end
    chk("mul_latency", 32'(bad), 32'd0);
    chk("mul_lit", 32'({alu_result, overflow}), {15'h0, 16'h0100, 1'b1});
    chk_out("mul", model(4'd8, 16'h0100, 16'h0101, 16'h0, 4'd5, 1));

    // Multiply disabled: illegal with single-cycle latency
    opcode_n = 4'd8; a_n = 16'h0100; b_n = 16'h0101; tag_n = 4'd5; in_valid_n = 1'b1;
    #1 chk("nomul_ready", 32'(in_ready_n), 32'd1);
    @(negedge clk);
    in_valid_n = 1'b0;
    chk("nomul_valid", 32'(out_valid_n), 32'd1);
    chk("nomul_ill", 32'({ill_n, res_n, zero_n, ovf_n}), {13'h0, 1'b1, 16'h0, 2'b00});
    chk("nomul_tag", 32'(out_tag_n), 32'd5);

    // Backpressure hold
    send(4'd0, 16'hF0F0, 16'h0FF0, 16'h0, 4'd3);
    out_ready = 1'b0;
    opcode = 4'd4; a = 16'h1234; b = 16'h00FF; in_tag = 4'd4; in_valid = 1'b1;
    #1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (in_ready || !out_valid || alu_result !== 16'h00F0 || out_tag !== 4'd3) bad++;
      @(negedge clk);
      #1;
    end
    chk("bp_hold", 32'(bad), 32'd0);
    out_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk_out("bp_xor", model(4'd4, 16'h1234, 16'h00FF, 16'h0, 4'd4, 1));
    chk("bp_xor_lit", 32'(alu_result), 32'h12CB);

    // Shifts, compare, illegal
    send(4'd7, 16'h8000, 16'h0013, 16'h0, 4'd6);
    chk("sra_lit", 32'(alu_result), 32'hF000);
    chk_out("sra", model(4'd7, 16'h8000, 16'h0013, 16'h0, 4'd6, 1));
    send(4'd6, 16'h0001, 16'd15, 16'h0, 4'd7);
    chk("sll_lit", 32'(alu_result), 32'h8000);
    send(4'd5, 16'hFFFF, 16'h0001, 16'h0, 4'd8);
    chk("slt_lit", 32'(alu_result), 32'h0001);
    chk_out("slt", model(4'd5, 16'hFFFF, 16'h0001, 16'h0, 4'd8, 1));
    send(4'd15, 16'h1234, 16'h5678, 16'h0, 4'd9);
    chk("ill_lit", 32'({illegal, alu_result, zero}), {14'h0, 1'b1, 16'h0, 1'b0});
    @(negedge clk);

    // Random traffic with random backpressure
    for (int cyc = 0; cyc < 1500; cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && $urandom_range(0, 4) != 0) begin
        opcode = 4'($urandom_range(0, 15));
        if (opcode == 4'd8 && $urandom_range(0, 2) != 0) opcode = 4'd2;
        a = W'($urandom); b = W'($urandom); immediate = W'($urandom);
        in_tag = TW'($urandom);
        in_valid = 1'b1;
      end
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk_out("rand", e);
        end
      end
      acc_now = in_valid && in_ready;
      if (acc_now) exp_q.push_back(model(opcode, a, b, immediate, in_tag, 1));
      @(negedge clk);
      if (acc_now) in_valid = 1'b0;
    end

    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (out_valid) begin
        if (exp_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk_out("drain", e);
        end
      end
      @(negedge clk);
    end
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
